// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: state codes,
// opcodes, ALU/mux select encodings and the control-strobe bundle.
// The ALU control decoder and the datapath import this package as well.
package mips_ctrl_pkg;

  // FSM state encodings (4 bits, also exported on the debug port)
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTEXEC  = 4'd6;
  localparam logic [3:0] S_RTWB    = 4'd7;
  localparam logic [3:0] S_BEQ     = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_IMMEX   = 4'd10;
  localparam logic [3:0] S_IMMWB   = 4'd11;
  localparam logic [3:0] S_ILLEGAL = 4'd12;  // one-cycle illegal_op pulse
  localparam logic [3:0] S_TRAP    = 4'd13;  // sticky trap, trap build only

  // Opcode constants
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation class sent to the ALU control decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  // ALU B-operand select
  typedef enum logic [1:0] {
    SRCB_B    = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } alusrcb_e;

  // Next-PC select
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_e;

  // Complete set of control strobes produced for one cycle
  typedef struct packed {
    logic     pc_write;
    logic     branch;
    logic     iord;
    logic     mem_read;
    logic     mem_write;
    logic     ir_write;
    logic     mem_to_reg;
    logic     reg_dst;
    logic     reg_write;
    logic     alu_src_a;
    logic     illegal_op;
    aluop_e   alu_op;
    alusrcb_e alu_src_b;
    pcsrc_e   pc_source;
  } ctrl_t;

  // True for opcodes the DECODE dispatch recognises
  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW:
        is_legal_op = 1'b1;
      default:
        is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Moore output decode: maps the current state (plus mem_ready while in
// FETCH) to the control strobes. Anything not set for a state stays 0.
// Macro ILLEGAL_OP_TRAP_EN adds decoding of the sticky TRAP state.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  // Per-state strobe table; default everything low
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // Latch the instruction and advance the PC only when memory delivers
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_IMMEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_RTEXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_RTWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.branch    = 1'b1;
        ctrl_o.pc_source = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_IMMWB: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_ILLEGAL: begin
        ctrl_o.illegal_op = 1'b1;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP: begin
        ctrl_o.illegal_op = 1'b1;
      end
`endif
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: state register, next-state logic and the
// output decoder. Build macro ILLEGAL_OP_TRAP_EN makes an unrecognised
// opcode lock the FSM in TRAP until reset instead of returning to FETCH.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       ALUop1,
  output logic       ALUop0,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       illegal_op,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] state
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctrl;
  ctrl_t      ctrl_gated;

  // State register; reset parks the FSM in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:             state_d = S_MEMADR;
          OP_RTYPE:                 state_d = S_RTEXEC;
          OP_BEQ:                   state_d = S_BEQ;
          OP_J:                     state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
`ifdef ILLEGAL_OP_TRAP_EN
          default:                  state_d = S_TRAP;
`else
          default:                  state_d = S_ILLEGAL;
`endif
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_RTEXEC: state_d = S_RTWB;
      S_IMMEX:  state_d = S_IMMWB;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      // MEMWB, RTWB, IMMWB, BEQ, JUMP, ILLEGAL and unused codes
      default:  state_d = S_FETCH;
    endcase
  end

  ctrl_output_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  // While reset is held, FETCH would otherwise drive MemRead; force all low
  always_comb begin
    ctrl_gated = rst_n ? ctrl : '0;
  end

  assign PCWrite    = ctrl_gated.pc_write;
  assign Branch     = ctrl_gated.branch;
  assign IorD       = ctrl_gated.iord;
  assign MemRead    = ctrl_gated.mem_read;
  assign MemWrite   = ctrl_gated.mem_write;
  assign IRWrite    = ctrl_gated.ir_write;
  assign MemtoReg   = ctrl_gated.mem_to_reg;
  assign RegDst     = ctrl_gated.reg_dst;
  assign RegWrite   = ctrl_gated.reg_write;
  assign ALUSrcA    = ctrl_gated.alu_src_a;
  assign illegal_op = ctrl_gated.illegal_op;
  assign ALUop1     = ctrl_gated.alu_op[1];
  assign ALUop0     = ctrl_gated.alu_op[0];
  assign ALUSrcB    = ctrl_gated.alu_src_b;
  assign PCSource   = ctrl_gated.pc_source;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// cycle by cycle against hand-written expected strobe vectors.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       ALUop1, ALUop0, PCWrite, Branch, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] state;
  logic [16:0] outs;

  int total = 0;
  int bad   = 0;

  // Expected strobes, bit order:
  // PCWrite Branch IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA illegal ALUop ALUSrcB PCSource
  localparam logic [16:0] V_IDLE  = 17'b0_0_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] V_FWAIT = 17'b0_0_0_1_0_0_0_0_0_0_0_00_01_00;
  localparam logic [16:0] V_FRDY  = 17'b1_0_0_1_0_1_0_0_0_0_0_00_01_00;
  localparam logic [16:0] V_DEC   = 17'b0_0_0_0_0_0_0_0_0_0_0_00_10_00;
  localparam logic [16:0] V_MADR  = 17'b0_0_0_0_0_0_0_0_0_1_0_00_10_00;
  localparam logic [16:0] V_MRD   = 17'b0_0_1_1_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] V_MWB   = 17'b0_0_0_0_0_0_1_0_1_0_0_00_00_00;
  localparam logic [16:0] V_MWR   = 17'b0_0_1_0_1_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] V_RTEX  = 17'b0_0_0_0_0_0_0_0_0_1_0_10_00_00;
  localparam logic [16:0] V_RTWB  = 17'b0_0_0_0_0_0_0_1_1_0_0_00_00_00;
  localparam logic [16:0] V_BEQ   = 17'b0_1_0_0_0_0_0_0_0_1_0_01_00_01;
  localparam logic [16:0] V_JMP   = 17'b1_0_0_0_0_0_0_0_0_0_0_00_00_10;
  localparam logic [16:0] V_IMMWB = 17'b0_0_0_0_0_0_0_0_1_0_0_00_00_00;
  localparam logic [16:0] V_ILL   = 17'b0_0_0_0_0_0_0_0_0_0_1_00_00_00;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .ALUop1     (ALUop1),
    .ALUop0     (ALUop0),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .illegal_op (illegal_op),
    .ALUSrcB    (ALUSrcB),
    .PCSource   (PCSource),
    .state      (state)
  );

  always #5 clk = ~clk;

  assign outs = {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegDst, RegWrite, ALUSrcA, illegal_op, ALUop1, ALUop0,
                 ALUSrcB, PCSource};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = OP_LW; mem_ready = 1'b1;
    #3;
    total++;
    if (outs !== V_IDLE || state !== S_FETCH) begin
      bad++;
      $display("FAIL reset_hold outs=%h state=%0d want outs=%h state=%0d", outs, state, V_IDLE, S_FETCH);
    end
    tick(); tick();
    total++;
    if (outs !== V_IDLE) begin
      bad++;
      $display("FAIL reset_clocked outs=%h want %h", outs, V_IDLE);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    total++;
    if (outs !== V_FWAIT || state !== S_FETCH) begin
      bad++;
      $display("FAIL reset_release outs=%h state=%0d want outs=%h state=%0d", outs, state, V_FWAIT, S_FETCH);
    end
    tick();
    total++;
    if (state !== S_FETCH) begin
      bad++;
      $display("FAIL reset_first_edge state=%0d want %0d", state, S_FETCH);
    end
    $display("reset: outs=%h state=%0d", outs, state);
  endtask

  task automatic test_lw();
    logic [3:0]  es [5];
    logic [16:0] ev [5];
    es = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
    ev = '{V_FRDY, V_DEC, V_MADR, V_MRD, V_MWB};
    opcode = OP_LW;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      #1;
      total++;
      if (state !== es[i] || outs !== ev[i]) begin
        bad++;
        $display("FAIL lw cyc%0d state=%0d outs=%h want state=%0d outs=%h", i, state, outs, es[i], ev[i]);
      end
      tick();
    end
    total++;
    if (state !== S_FETCH) begin
      bad++;
      $display("FAIL lw_return state=%0d want %0d", state, S_FETCH);
    end
    $display("lw: 5 cycles checked, state=%0d", state);
  endtask

  task automatic test_sw_wait();
    logic [3:0]  es [6];
    logic [16:0] ev [6];
    logic        mr [6];
    es = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_MEMWR, S_MEMWR};
    ev = '{V_FRDY, V_DEC, V_MADR, V_MWR, V_MWR, V_MWR};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    opcode = OP_SW;
    for (int i = 0; i < 6; i++) begin
      mem_ready = mr[i];
      #1;
      total++;
      if (state !== es[i] || outs !== ev[i]) begin
        bad++;
        $display("FAIL sw cyc%0d state=%0d outs=%h want state=%0d outs=%h", i, state, outs, es[i], ev[i]);
      end
      tick();
    end
    total++;
    if (state !== S_FETCH) begin
      bad++;
      $display("FAIL sw_return state=%0d want %0d", state, S_FETCH);
    end
    $display("sw: 2 wait states, state=%0d", state);
  endtask

  task automatic test_rtype_wait();
    logic [3:0]  es [6];
    logic [16:0] ev [6];
    logic        mr [6];
    int          ir_count;
    es = '{S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_RTEXEC, S_RTWB};
    ev = '{V_FWAIT, V_FWAIT, V_FRDY, V_DEC, V_RTEX, V_RTWB};
    mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ir_count = 0;
    opcode = OP_RTYPE;
    for (int i = 0; i < 6; i++) begin
      mem_ready = mr[i];
      #1;
      total++;
      if (state !== es[i] || outs !== ev[i]) begin
        bad++;
        $display("FAIL rtype cyc%0d state=%0d outs=%h want state=%0d outs=%h", i, state, outs, es[i], ev[i]);
      end
      if (IRWrite === 1'b1) ir_count++;
      tick();
    end
    total++;
    if (ir_count !== 1) begin
      bad++;
      $display("FAIL rtype_irwrite count=%0d want 1", ir_count);
    end
    total++;
    if (state !== S_FETCH) begin
      bad++;
      $display("FAIL rtype_return state=%0d want %0d", state, S_FETCH);
    end
    $display("rtype: 6 cycles, IRWrite pulses=%0d", ir_count);
  endtask

  task automatic test_branch_jump();
    logic [5:0]  ops [2];
    logic [16:0] ev3 [2];
    logic [3:0]  es3 [2];
    ops = '{OP_BEQ, OP_J};
    ev3 = '{V_BEQ, V_JMP};
    es3 = '{S_BEQ, S_JUMP};
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k];
      #1;
      total++;
      if (outs !== V_FRDY) begin
        bad++;
        $display("FAIL br%0d_fetch outs=%h want %h", k, outs, V_FRDY);
      end
      tick();
      total++;
      if (state !== S_DECODE || outs !== V_DEC) begin
        bad++;
        $display("FAIL br%0d_decode state=%0d outs=%h want state=%0d outs=%h", k, state, outs, S_DECODE, V_DEC);
      end
      tick();
      total++;
      if (state !== es3[k] || outs !== ev3[k]) begin
        bad++;
        $display("FAIL br%0d_exec state=%0d outs=%h want state=%0d outs=%h", k, state, outs, es3[k], ev3[k]);
      end
      tick();
      total++;
      if (state !== S_FETCH) begin
        bad++;
        $display("FAIL br%0d_return state=%0d want %0d", k, state, S_FETCH);
      end
      $display("branch/jump op=%b: 3 cycles", ops[k]);
    end
  endtask

  task automatic test_imm();
    logic [5:0] ops [3];
    ops = '{OP_ADDI, OP_ANDI, OP_ORI};
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k];
      tick();  // FETCH -> DECODE
      tick();  // DECODE -> IMMEX
      total++;
      if (state !== S_IMMEX || outs !== V_MADR) begin
        bad++;
        $display("FAIL imm_ex op=%b state=%0d outs=%h want state=%0d outs=%h", ops[k], state, outs, S_IMMEX, V_MADR);
      end
      tick();
      total++;
      if (state !== S_IMMWB || outs !== V_IMMWB) begin
        bad++;
        $display("FAIL imm_wb op=%b state=%0d outs=%h want state=%0d outs=%h", ops[k], state, outs, S_IMMWB, V_IMMWB);
      end
      tick();
      total++;
      if (state !== S_FETCH) begin
        bad++;
        $display("FAIL imm_return op=%b state=%0d want %0d", ops[k], state, S_FETCH);
      end
      $display("imm op=%b: 4 cycles", ops[k]);
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2];
    ops = '{6'b111111, 6'b000001};
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k];
      tick();  // FETCH -> DECODE
      total++;
      if (outs !== V_DEC) begin
        bad++;
        $display("FAIL ill_decode op=%b outs=%h want %h", ops[k], outs, V_DEC);
      end
      tick();
      total++;
      if (outs !== V_ILL) begin
        bad++;
        $display("FAIL ill_pulse op=%b outs=%h want %h", ops[k], outs, V_ILL);
      end
`ifdef ILLEGAL_OP_TRAP_EN
      for (int c = 0; c < 4; c++) begin
        tick();
        total++;
        if (outs !== V_ILL || state !== S_TRAP) begin
          bad++;
          $display("FAIL trap_hold op=%b cyc%0d state=%0d outs=%h want state=%0d outs=%h", ops[k], c, state, outs, S_TRAP, V_ILL);
        end
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if (outs !== V_IDLE || state !== S_FETCH) begin
        bad++;
        $display("FAIL trap_reset outs=%h state=%0d", outs, state);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      mem_ready = 1'b1;
      $display("trap op=%b: held then reset", ops[k]);
`else
      tick();
      total++;
      if (state !== S_FETCH || outs !== V_FRDY) begin
        bad++;
        $display("FAIL ill_return op=%b state=%0d outs=%h want state=%0d outs=%h", ops[k], state, outs, S_FETCH, V_FRDY);
      end
      $display("illegal op=%b: one-cycle pulse", ops[k]);
`endif
    end
  endtask

  task automatic test_reset_mid();
    opcode = OP_SW;
    mem_ready = 1'b1;
    tick(); tick(); tick();  // FETCH, DECODE, MEMADR
    mem_ready = 1'b0;
    #1;
    total++;
    if (state !== S_MEMWR || outs !== V_MWR) begin
      bad++;
      $display("FAIL mid_memwr state=%0d outs=%h want state=%0d outs=%h", state, outs, S_MEMWR, V_MWR);
    end
    #1;
    rst_n = 1'b0;  // asynchronous, between clock edges
    #1;
    total++;
    if (outs !== V_IDLE || state !== S_FETCH) begin
      bad++;
      $display("FAIL mid_async outs=%h state=%0d want outs=%h state=%0d", outs, state, V_IDLE, S_FETCH);
    end
    mem_ready = 1'b1;
    tick();
    total++;
    if (MemWrite !== 1'b0 || outs !== V_IDLE) begin
      bad++;
      $display("FAIL mid_no_write outs=%h want %h", outs, V_IDLE);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    total++;
    if (state !== S_FETCH || outs !== V_FWAIT) begin
      bad++;
      $display("FAIL mid_restart state=%0d outs=%h want state=%0d outs=%h", state, outs, S_FETCH, V_FWAIT);
    end
    tick();
    $display("reset mid-MEMWR: outs zeroed, restart in FETCH");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype_wait();
    test_branch_jump();
    test_imm();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
